// File: rtl/ndn_pit_bucket_table_if.sv
// Request/response bundle between the hash stage, the PIT bucket table and the face-select logic.
interface ndn_pit_bucket_table_if #(
    parameter int HASH_W = 10,
    parameter int KEY_W  = 64,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [HASH_W-1:0] req_hash;
    logic [KEY_W-1:0]  req_key;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_status;
    logic [DATA_W-1:0] resp_data;
    logic [HASH_W:0]   occupancy;

    modport master (
        output req_valid, req_op, req_hash, req_key, req_data, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_data, occupancy
    );

    modport slave (
        input  req_valid, req_op, req_hash, req_key, req_data, resp_ready,
        output req_ready, resp_valid, resp_status, resp_data, occupancy
    );
endinterface

// File: rtl/ndn_pit_bucket_table.sv
// Direct-mapped PIT bucket store: hash-indexed key/face-bitmap array with exact key confirmation.
// Optional hit/miss/collision counters are compiled in with `define PIT_STATS_EN.
module ndn_pit_bucket_table #(
    parameter int HASH_W = 10,
    parameter int KEY_W  = 64,
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst,
    ndn_pit_bucket_table_if.slave bus
`ifdef PIT_STATS_EN
    ,
    output logic [15:0] stat_hit,
    output logic [15:0] stat_miss,
    output logic [15:0] stat_collision
`endif
);
    localparam int DEPTH = 1 << HASH_W;
    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_HIT    = 2'b01;
    localparam logic [1:0] ST_MISS   = 2'b10;
    localparam logic [1:0] ST_COLL   = 2'b11;
    localparam logic [HASH_W:0] OCC_ONE = {{HASH_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CMP, S_RESP} state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) return v;
        else return v + 16'd1;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [1:0]          r_op;
    logic [HASH_W-1:0]   r_hash;
    logic [KEY_W-1:0]    r_key;
    logic [DATA_W-1:0]   r_data;
    logic [KEY_W-1:0]    r_rd_key;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DEPTH-1:0]    r_valid;
    logic [HASH_W:0]     r_occ;
    logic [1:0]          r_status;
    logic [DATA_W-1:0]   r_resp_data;
    logic [KEY_W-1:0]    r_mem_key  [DEPTH];
    logic [DATA_W-1:0]   r_mem_data [DEPTH];

    logic                w_accept;
    logic                w_hit;
    logic [1:0]          w_status;
    logic [DATA_W-1:0]   w_data;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_set_valid;
    logic                w_clr_valid;
    logic                w_flush;
    logic                w_occ_inc;
    logic                w_occ_dec;

    assign w_accept        = bus.req_valid && r_req_ready;
    assign w_hit           = r_valid[r_hash] && (r_rd_key == r_key);
    assign bus.req_ready   = r_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_status = r_status;
    assign bus.resp_data   = r_resp_data;
    assign bus.occupancy   = r_occ;

    // Next-state and CMP-stage decision logic
    always_comb begin
        w_state_nxt = r_state;
        w_status    = ST_OK;
        w_data      = {DATA_W{1'b0}};
        w_wr_en     = 1'b0;
        w_wr_data   = r_data;
        w_set_valid = 1'b0;
        w_clr_valid = 1'b0;
        w_flush     = 1'b0;
        w_occ_inc   = 1'b0;
        w_occ_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_READ;
                else w_state_nxt = S_IDLE;
            end
            S_READ: w_state_nxt = S_CMP;
            S_CMP: begin
                w_state_nxt = S_RESP;
                case (r_op)
                    OP_LOOKUP: begin
                        if (w_hit) begin
                            w_status = ST_HIT;
                            w_data   = r_rd_data;
                        end else begin
                            w_status = ST_MISS;
                        end
                    end
                    OP_INSERT: begin
                        if (!r_valid[r_hash]) begin
                            w_wr_en     = 1'b1;
                            w_set_valid = 1'b1;
                            w_occ_inc   = 1'b1;
                            w_status    = ST_OK;
                            w_data      = r_data;
                        end else if (w_hit) begin
                            w_wr_en   = 1'b1;
                            w_wr_data = r_rd_data | r_data;
                            w_status  = ST_HIT;
                            w_data    = r_rd_data | r_data;
                        end else begin
                            w_status = ST_COLL;
                        end
                    end
                    OP_DELETE: begin
                        if (w_hit) begin
                            w_clr_valid = 1'b1;
                            w_occ_dec   = 1'b1;
                            w_status    = ST_OK;
                            w_data      = r_rd_data;
                        end else begin
                            w_status = ST_MISS;
                        end
                    end
                    default: begin
                        w_flush  = 1'b1;
                        w_status = ST_OK;
                    end
                endcase
            end
            S_RESP: begin
                if (r_resp_valid && bus.resp_ready) w_state_nxt = S_IDLE;
                else w_state_nxt = S_RESP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, handshake flags and the latched request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_op         <= 2'b00;
            r_hash       <= {HASH_W{1'b0}};
            r_key        <= {KEY_W{1'b0}};
            r_data       <= {DATA_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            // Valid rises one cycle into RESP, after status/data have settled
            r_resp_valid <= (r_state == S_RESP) && (w_state_nxt == S_RESP);
            if (r_state == S_IDLE && w_accept) begin
                r_op   <= bus.req_op;
                r_hash <= bus.req_hash;
                r_key  <= bus.req_key;
                r_data <= bus.req_data;
            end
        end
    end

    // Response registers, bucket valid bits and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status    <= ST_OK;
            r_resp_data <= {DATA_W{1'b0}};
            r_valid     <= {DEPTH{1'b0}};
            r_occ       <= {(HASH_W+1){1'b0}};
        end else begin
            if (r_state == S_CMP) begin
                r_status    <= w_status;
                r_resp_data <= w_data;
            end
            if (w_flush) r_valid <= {DEPTH{1'b0}};
            else if (w_set_valid) r_valid[r_hash] <= 1'b1;
            else if (w_clr_valid) r_valid[r_hash] <= 1'b0;
            if (w_flush) r_occ <= {(HASH_W+1){1'b0}};
            else if (w_occ_inc) r_occ <= r_occ + OCC_ONE;
            else if (w_occ_dec) r_occ <= r_occ - OCC_ONE;
        end
    end

    // Unreset key/data array; a write coinciding with rst is dropped
    always_ff @(posedge clk) begin
        if (r_state == S_READ) begin
            r_rd_key  <= r_mem_key[r_hash];
            r_rd_data <= r_mem_data[r_hash];
        end
        if (w_wr_en && !rst) begin
            r_mem_key[r_hash]  <= r_key;
            r_mem_data[r_hash] <= w_wr_data;
        end
    end

`ifdef PIT_STATS_EN
    // Saturating outcome counters; survive FLUSH, cleared only by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hit       <= 16'd0;
            stat_miss      <= 16'd0;
            stat_collision <= 16'd0;
        end else if (r_state == S_CMP) begin
            case (w_status)
                ST_HIT:  stat_hit       <= sat_inc16(stat_hit);
                ST_MISS: stat_miss      <= sat_inc16(stat_miss);
                ST_COLL: stat_collision <= sat_inc16(stat_collision);
                default: stat_hit       <= stat_hit;
            endcase
        end
    end
`else
    // Counters and their ports are compiled out.
`endif
endmodule

// File: tb/tb_ndn_pit_bucket_table.sv
// Directed, table-driven bench for ndn_pit_bucket_table plus stall and reset-abort sequences.
module tb_ndn_pit_bucket_table;
    localparam logic [1:0] LK = 2'b00, IN = 2'b01, DL = 2'b10, FL = 2'b11;
    localparam logic [1:0] OK = 2'b00, HT = 2'b01, MS = 2'b10, CO = 2'b11;
    localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'hDEADBEEF00000001;
    localparam logic [63:0] K3 = 64'h5555AAAA5555AAAA;

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  hash;
        logic [63:0] key;
        logic [7:0]  data;
        logic [1:0]  st;
        logic [7:0]  rdata;
        logic [10:0] occ;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs [0:17];

    ndn_pit_bucket_table_if #(.HASH_W(10), .KEY_W(64), .DATA_W(8)) ifc ();

`ifdef PIT_STATS_EN
    logic [15:0] stat_hit, stat_miss, stat_collision;
`endif

    ndn_pit_bucket_table #(.HASH_W(10), .KEY_W(64), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
`ifdef PIT_STATS_EN
        ,
        .stat_hit       (stat_hit),
        .stat_miss      (stat_miss),
        .stat_collision (stat_collision)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one request and check latency, response and occupancy (resp_ready assumed 1)
    task automatic run_vec(input vec_t v, input string nm);
        int k;
        @(negedge clk);
        for (k = 0; k < 20 && !ifc.req_ready; k++) @(negedge clk);
        chk({nm, " req_ready"}, 64'(ifc.req_ready), 64'd1);
        ifc.req_valid = 1'b1;
        ifc.req_op    = v.op;
        ifc.req_hash  = v.hash;
        ifc.req_key   = v.key;
        ifc.req_data  = v.data;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk({nm, " early_valid"}, 64'(ifc.resp_valid), 64'd0);
        @(posedge clk); #1;
        chk({nm, " resp_valid"}, 64'(ifc.resp_valid), 64'd1);
        chk({nm, " status"}, 64'(ifc.resp_status), 64'(v.st));
        chk({nm, " data"}, 64'(ifc.resp_data), 64'(v.rdata));
        @(posedge clk); #1;
        chk({nm, " valid_drop"}, 64'(ifc.resp_valid), 64'd0);
        chk({nm, " occupancy"}, 64'(ifc.occupancy), 64'(v.occ));
    endtask

    function automatic vec_t mk(logic [1:0] op, logic [9:0] h, logic [63:0] k, logic [7:0] d,
                                logic [1:0] st, logic [7:0] rd, logic [10:0] occ);
        vec_t v;
        v.op = op; v.hash = h; v.key = k; v.data = d; v.st = st; v.rdata = rd; v.occ = occ;
        return v;
    endfunction

    initial begin
        bit seen;
        checks   = 0;
        failures = 0;
        vecs[0]  = mk(LK, 10'h155, K1, 8'h00, MS, 8'h00, 11'd0);
        vecs[1]  = mk(IN, 10'h155, K1, 8'h03, OK, 8'h03, 11'd1);
        vecs[2]  = mk(LK, 10'h155, K1, 8'h00, HT, 8'h03, 11'd1);
        vecs[3]  = mk(IN, 10'h155, K1, 8'h04, HT, 8'h07, 11'd1);
        vecs[4]  = mk(IN, 10'h155, K2, 8'h10, CO, 8'h00, 11'd1);
        vecs[5]  = mk(LK, 10'h155, K1, 8'h00, HT, 8'h07, 11'd1);
        vecs[6]  = mk(DL, 10'h155, K1, 8'h00, OK, 8'h07, 11'd0);
        vecs[7]  = mk(DL, 10'h155, K1, 8'h00, MS, 8'h00, 11'd0);
        vecs[8]  = mk(IN, 10'h000, K1, 8'h01, OK, 8'h01, 11'd1);
        vecs[9]  = mk(IN, 10'h3FF, K2, 8'h02, OK, 8'h02, 11'd2);
        vecs[10] = mk(IN, 10'h200, K3, 8'h80, OK, 8'h80, 11'd3);
        vecs[11] = mk(LK, 10'h3FF, K1, 8'h00, MS, 8'h00, 11'd3);
        vecs[12] = mk(DL, 10'h200, K1, 8'h00, MS, 8'h00, 11'd3);
        vecs[13] = mk(LK, 10'h3FF, K2, 8'h00, HT, 8'h02, 11'd3);
        vecs[14] = mk(FL, 10'h000, K1, 8'hFF, OK, 8'h00, 11'd0);
        vecs[15] = mk(LK, 10'h000, K1, 8'h00, MS, 8'h00, 11'd0);
        vecs[16] = mk(LK, 10'h3FF, K2, 8'h00, MS, 8'h00, 11'd0);
        vecs[17] = mk(LK, 10'h200, K3, 8'h00, MS, 8'h00, 11'd0);

        rst = 1'b1;
        ifc.req_valid = 1'b0; ifc.req_op = 2'b00; ifc.req_hash = 10'h000;
        ifc.req_key = 64'h0; ifc.req_data = 8'h00; ifc.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 64'(ifc.req_ready), 64'd1);
        chk("reset resp_valid", 64'(ifc.resp_valid), 64'd0);
        chk("reset resp_status", 64'(ifc.resp_status), 64'd0);
        chk("reset resp_data", 64'(ifc.resp_data), 64'd0);
        chk("reset occupancy", 64'(ifc.occupancy), 64'd0);
`ifdef PIT_STATS_EN
        chk("reset stat_hit", 64'(stat_hit), 64'd0);
        chk("reset stat_miss", 64'(stat_miss), 64'd0);
        chk("reset stat_collision", 64'(stat_collision), 64'd0);
`endif

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: response held 5 cycles while a stray DELETE is presented
        ifc.resp_ready = 1'b0;
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_op = LK; ifc.req_hash = 10'h155; ifc.req_key = K1;
        ifc.req_data = 8'h00;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("stall first valid", 64'(ifc.resp_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            ifc.req_valid = 1'b1; ifc.req_op = DL;
            @(posedge clk); #1;
            chk($sformatf("stall%0d valid", c), 64'(ifc.resp_valid), 64'd1);
            chk($sformatf("stall%0d status", c), 64'(ifc.resp_status), 64'(HT));
            chk($sformatf("stall%0d data", c), 64'(ifc.resp_data), 64'h07);
            chk($sformatf("stall%0d req_ready", c), 64'(ifc.req_ready), 64'd0);
        end
        ifc.req_valid = 1'b0;
        ifc.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall release valid", 64'(ifc.resp_valid), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ifc.resp_valid) seen = 1'b1;
        end
        chk("stray req ignored", 64'(seen), 64'd0);

        for (int i = 6; i < 18; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while the accepted INSERT sits in READ
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_op = IN; ifc.req_hash = 10'h0AA; ifc.req_key = K1;
        ifc.req_data = 8'h55;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ifc.resp_valid) seen = 1'b1;
        end
        chk("rst abort no resp", 64'(seen), 64'd0);
        chk("rst abort req_ready", 64'(ifc.req_ready), 64'd1);
        chk("rst abort occupancy", 64'(ifc.occupancy), 64'd0);
`ifdef PIT_STATS_EN
        chk("rst abort stat_hit", 64'(stat_hit), 64'd0);
`endif
        run_vec(mk(LK, 10'h0AA, K1, 8'h00, MS, 8'h00, 11'd0), "post-rst lookup");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule
